// File: rtl/frame_writer.sv
// Streams one raster frame of pixels into image buffer 0 or 1, one handshaked memory write per pixel.
// Optional FRAME_WRITER_SAT_EN clamps 9-bit pixels above 255 to 9'h0FF before writing.
module frame_writer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int IMG1_BASE = 307210
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        image,
  input  logic        in_valid,
  input  logic [8:0]  in_pixel,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [8:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [31:0]   BASE1  = IMG1_BASE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_ACK,
    DONE
  } state_t;

  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [31:0]   lin_q;
  logic          img_sel_q;
  logic          in_ready_q;
  logic          mem_we_q;
  logic [31:0]   mem_adr_q;
  logic [8:0]    mem_wdata_q;
  logic          busy_q;
  logic          frame_done_q;

  logic [8:0]    pix_d;
  logic [31:0]   adr_d;

`ifdef FRAME_WRITER_SAT_EN
  assign pix_d = (in_pixel > 9'd255) ? 9'h0FF : in_pixel;
`else
  assign pix_d = in_pixel;
`endif

  // lin tracks y*H_RES+x incrementally so no multiplier is needed for the address
  assign adr_d = (img_sel_q ? BASE1 : 32'd0) + lin_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      lin_q        <= 32'd0;
      img_sel_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_adr_q    <= 32'd0;
      mem_wdata_q  <= 9'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            img_sel_q  <= image;
            x_q        <= '0;
            y_q        <= '0;
            lin_q      <= 32'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (in_valid && in_ready_q) begin
            mem_wdata_q <= pix_d;
            mem_adr_q   <= adr_d;
            mem_we_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            state_q     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // write request stays frozen until the memory acknowledges it
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            lin_q    <= lin_q + 32'd1;
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                frame_done_q <= 1'b1;
                state_q      <= DONE;
              end else begin
                y_q        <= y_q + 1'b1;
                in_ready_q <= 1'b1;
                state_q    <= RUN;
              end
            end else begin
              x_q        <= x_q + 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= RUN;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          mem_we_q   <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_adr    = mem_adr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
